fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 128 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side controller for a single-clock FIFO memory.
// Owns the read pointer and detects empty against the write pointer.
// Issues memory read enables and hides the one-cycle read latency
// behind a 2-entry first-word-fall-through output buffer.
//
// Ports:
//   rd_clk, rd_rst      clock, synchronous active-high reset
//   wr_addr, wr_phase   write-side next-write address and wrap bit
//   rd_addr, rd_phase   registered read address and wrap bit
//   rd_en, rd_data      memory read enable; data valid one cycle later
//   fifo_empty          combinational empty flag
//   out_data/valid/rdy  downstream valid/ready stream
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 8,
    parameter int DEPTH    = 90
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDRSIZE-2:0]   wr_addr,
    input  logic                  wr_phase,
    output logic [ADDRSIZE-2:0]   rd_addr,
    output logic                  rd_phase,
    output logic                  rd_en,
    input  logic [DATASIZE-1:0]   rd_data,
    output logic                  fifo_empty,
    output logic [DATASIZE-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = ADDRSIZE - 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic                rd_phase_q, rd_phase_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          buf_cnt_q, buf_cnt_d;
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] tail_q, tail_d;

    logic       pop;
    logic [1:0] occ;

    always_comb begin
        rd_addr_d  = rd_addr_q;
        rd_phase_d = rd_phase_q;
        buf_cnt_d  = buf_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;

        fifo_empty = (rd_addr_q == wr_addr) && (rd_phase_q == wr_phase);
        out_valid  = (buf_cnt_q != 2'd0);
        pop        = out_valid && out_ready;

        // Words already owned by the buffer, including one still
        // coming back from memory. A pop frees a slot this cycle.
        occ   = buf_cnt_q + {1'b0, inflight_q};
        rd_en = !rd_rst && !fifo_empty &&
                ((occ < 2'd2) || ((occ == 2'd2) && pop));

        if (rd_en) begin
            if (rd_addr_q == LAST_ADDR) begin
                rd_addr_d  = '0;
                rd_phase_d = ~rd_phase_q;
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end
        inflight_d = rd_en;

        // Capture lands behind any surviving entry; order is kept.
        unique case (buf_cnt_q)
            2'd0: begin
                if (inflight_q) begin
                    head_d    = rd_data;
                    buf_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (inflight_q && pop) begin
                    head_d = rd_data;
                end else if (inflight_q) begin
                    tail_d    = rd_data;
                    buf_cnt_d = 2'd2;
                end else if (pop) begin
                    buf_cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (inflight_q) begin
                        tail_d = rd_data;
                    end else begin
                        buf_cnt_d = 2'd1;
                    end
                end
            end
            default: begin
                buf_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_addr_q  <= '0;
            rd_phase_q <= 1'b0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            rd_phase_q <= rd_phase_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign rd_phase = rd_phase_q;
    assign out_data = head_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream.
// Models the FIFO memory and write side; checks the output stream.
module tb_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int ASZ   = 8;
    localparam int AW    = ASZ - 1;
    localparam int DEPTH = 90;

    logic          clk = 1'b0;
    logic          rd_rst;
    logic [AW-1:0] wr_addr;
    logic          wr_phase;
    logic [AW-1:0] rd_addr;
    logic          rd_phase;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          fifo_empty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expq [$];

    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data;

    fifo_rd_stream #(
        .DATASIZE (DW),
        .ADDRSIZE (ASZ),
        .DEPTH    (DEPTH)
    ) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .wr_addr    (wr_addr),
        .wr_phase   (wr_phase),
        .rd_addr    (rd_addr),
        .rd_phase   (rd_phase),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Registered-read memory.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write side: store word, then publish it by advancing the pointer.
    task automatic push(input logic [DW-1:0] d);
        mem[wr_addr] = d;
        expq.push_back(d);
        if (int'(wr_addr) == DEPTH - 1) begin
            wr_addr  = '0;
            wr_phase = ~wr_phase;
        end else begin
            wr_addr = wr_addr + 1'b1;
        end
    endtask

    task automatic start_reset();
        rd_rst   = 1'b1;
        expq.delete();
        wr_addr  = '0;
        wr_phase = 1'b0;
    endtask

    task automatic drain(input int bound);
        int i;
        i = 0;
        while ((expq.size() != 0 || out_valid) && i < bound) begin
            tick();
            i++;
        end
        chk("drain_left", expq.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rd_rst) begin
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (int'(rd_addr) >= DEPTH) begin
                errors++;
                $display("FAIL rd_addr_range got %0d limit %0d",
                         rd_addr, DEPTH);
            end
            if (stall_prev && out_valid) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold got %0h expected %0h",
                             out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got %0h expected none",
                             out_data);
                end else begin
                    logic [DW-1:0] e;
                    e = expq.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL stream got %0h expected %0h",
                                 out_data, e);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rd_rst    = 1'b1;
        wr_addr   = AW'(5);
        wr_phase  = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with a non-zero write pointer.
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_rd_phase", rd_phase, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_rd_en", rd_en, 0);
        end
        start_reset();
        tick();
        rd_rst = 1'b0;
        tick();

        // Single word.
        out_ready = 1'b1;
        push(8'hA5);
        #1;
        chk("single_rd_en_c0", rd_en, 1);
        tick();
        tick();
        chk("single_valid_c2", out_valid, 1);
        chk("single_data_c2", out_data, 8'hA5);
        chk("single_rd_addr", rd_addr, 1);
        tick();

        // Burst of five.
        for (int i = 1; i <= 5; i++) push(DW'(i));
        #1;
        chk("burst_not_empty", fifo_empty, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 2 && k <= 6) chk("burst_valid", out_valid, 1);
            if (k == 7) chk("burst_valid_end", out_valid, 0);
            if (k == 5) chk("burst_empty", fifo_empty, 1);
        end

        // Backpressure: six words, consumer stalled four cycles.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DW'(i));
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (rd_en) cnt++;
            if (k >= 2) begin
                chk("bp_valid", out_valid, 1);
                chk("bp_data", out_data, 8'h01);
            end
            tick();
        end
        chk("bp_rd_en_count", cnt, 2);
        out_ready = 1'b1;
        drain(200);

        // Wrap and full.
        start_reset();
        tick();
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) push(DW'($urandom));
        drain(400);
        chk("wrap_pre_addr", rd_addr, DEPTH - 1);
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) push(DW'($urandom));
        #1;
        chk("full_not_empty", fifo_empty, 0);
        chk("full_rd_en", rd_en, 1);
        tick();
        chk("wrap_addr", rd_addr, 0);
        chk("wrap_phase", rd_phase, 1);
        out_ready = 1'b1;
        drain(400);
        chk("wrap_empty", fifo_empty, 1);
        chk("wrap_end_addr", rd_addr, DEPTH - 1);
        chk("wrap_end_phase", rd_phase, 1);

        // Reset mid-burst with a read in flight.
        tick();
        for (int i = 0; i < 6; i++) push(DW'(8'h40 + i));
        tick();
        tick();
        tick();
        start_reset();
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_addr", rd_addr, 0);
        rd_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid_rst_quiet", out_valid, 0);
        end

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            int n;
            out_ready = (($urandom % 10) < 7);
            n = int'($urandom % 3);
            if (expq.size() + n <= DEPTH) begin
                for (int j = 0; j < n; j++) push(DW'($urandom));
            end
            tick();
        end
        out_ready = 1'b1;
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
